// File: rtl/spi_cmd_queue.sv
// SPI LCD command queue: buffers CPU-written 10-bit LCD words and issues them to the SPI driver.
// Optional macro SPI_CMDQ_DELAY_EN turns {2'b11, n} entries into n*DELAY_UNIT-clock waits.

module spi_cmd_queue #(
    parameter int DEPTH      = 16,
    parameter int AW         = 4,
    parameter int GAP_CYCLES = 25,
    parameter int DELAY_UNIT = 62500
) (
    input  logic        clk,
    input  logic        reset_,
    input  logic        wr_en,
    input  logic [9:0]  wr_data,
    input  logic        clr_ovf,
    input  logic        spi_cs_,
    output logic        spi_start,
    output logic [9:0]  spi_din,
    output logic [31:0] status,
    output logic        busy
);

    localparam int          CW       = ($clog2(GAP_CYCLES + 1) < 3) ? 3 : $clog2(GAP_CYCLES + 1);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
`ifdef SPI_CMDQ_DELAY_EN
    localparam int          DW       = $clog2(255 * DELAY_UNIT + 1);
`endif

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_LO,
        WAIT_HI,
        GAP
`ifdef SPI_CMDQ_DELAY_EN
        ,
        DELAY
`endif
    } state_t;

    state_t        state_reg, state_next;
    logic [9:0]    mem [DEPTH];
    logic [9:0]    head;
    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [AW:0]   count_reg, count_next;
    logic          ovf_reg, ovf_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          spi_start_reg;
    logic [9:0]    spi_din_reg, spi_din_next;
    logic          full, empty, push, pop, issue;
`ifdef SPI_CMDQ_DELAY_EN
    logic          dly_load;
    logic [DW-1:0] dly_reg, dly_next;
`endif

    if (DEPTH != (1 << AW) || AW > 11 || GAP_CYCLES < 1 || DELAY_UNIT < 1) begin : g_param_check
        $error("spi_cmd_queue: DEPTH must equal 2**AW, AW <= 11, GAP_CYCLES and DELAY_UNIT >= 1");
    end

    assign full  = (count_reg == FULL_CNT);
    assign empty = (count_reg == '0);
    // Space check uses the registered count only, so a same-cycle pop never admits a push.
    assign push  = wr_en && !full;
    assign head  = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM: outputs (pop/issue decisions taken in IDLE)
    always_comb begin
        pop   = 1'b0;
        issue = 1'b0;
`ifdef SPI_CMDQ_DELAY_EN
        dly_load = 1'b0;
`endif
        if (state_reg == IDLE && !empty && spi_cs_) begin
            pop = 1'b1;
`ifdef SPI_CMDQ_DELAY_EN
            if (head[9:8] == 2'b11) begin
                dly_load = 1'b1;
            end else begin
                issue = 1'b1;
            end
`else
            issue = 1'b1;
`endif
        end
    end

    // FSM: next state
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (issue) begin
                    state_next = ISSUE;
                end
`ifdef SPI_CMDQ_DELAY_EN
                else if (dly_load) begin
                    state_next = DELAY;
                end
`endif
            end
            // Power-on words keep cs_ high forever, so there is no transfer to wait for.
            ISSUE:   state_next = spi_din_reg[9] ? GAP : WAIT_LO;
            WAIT_LO: begin
                if (!spi_cs_) begin
                    state_next = WAIT_HI;
                end else if (cnt_reg == CW'(3)) begin
                    state_next = GAP;
                end
            end
            WAIT_HI: begin
                if (spi_cs_) begin
                    state_next = GAP;
                end
            end
            GAP: begin
                if (cnt_reg == CW'(GAP_CYCLES - 1)) begin
                    state_next = IDLE;
                end
            end
`ifdef SPI_CMDQ_DELAY_EN
            DELAY: begin
                if (dly_reg <= DW'(1)) begin
                    state_next = IDLE;
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    // Shared cycle counter for the WAIT_LO timeout and GAP; restarts on every state change.
    always_comb begin
        cnt_next = '0;
        if (state_next == state_reg && (state_reg == WAIT_LO || state_reg == GAP)) begin
            cnt_next = cnt_reg + CW'(1);
        end
    end

    always_comb begin
        wr_ptr_next  = wr_ptr_reg;
        rd_ptr_next  = rd_ptr_reg;
        count_next   = count_reg;
        ovf_next     = ovf_reg;
        spi_din_next = spi_din_reg;
        if (push) begin
            wr_ptr_next = wr_ptr_reg + AW'(1);
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_next = count_reg + (AW+1)'(1);
            2'b01:   count_next = count_reg - (AW+1)'(1);
            default: count_next = count_reg;
        endcase
        if (wr_en && full) begin
            ovf_next = 1'b1;
        end else if (clr_ovf) begin
            ovf_next = 1'b0;
        end
        if (issue) begin
            spi_din_next = head;
        end
    end

`ifdef SPI_CMDQ_DELAY_EN
    always_comb begin
        dly_next = dly_reg;
        if (dly_load) begin
            dly_next = DW'(head[7:0]) * DW'(DELAY_UNIT);
        end else if (state_reg == DELAY && dly_reg != '0) begin
            dly_next = dly_reg - DW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            dly_reg <= '0;
        end else begin
            dly_reg <= dly_next;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            ovf_reg       <= 1'b0;
            cnt_reg       <= '0;
            spi_start_reg <= 1'b0;
            spi_din_reg   <= '0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            ovf_reg       <= ovf_next;
            cnt_reg       <= cnt_next;
            spi_start_reg <= issue;
            spi_din_reg   <= spi_din_next;
        end
    end

    assign spi_start = spi_start_reg;
    assign spi_din   = spi_din_reg;
    assign busy      = (state_reg != IDLE) || !empty;

    assign status[31:16] = 16'h0;
    assign status[15]    = ovf_reg;
    assign status[14]    = busy;
    assign status[13]    = full;
    assign status[12]    = empty;

    genvar gi;
    for (gi = 0; gi < 12; gi++) begin : g_status_count
        if (gi <= AW) begin : g_cnt
            assign status[gi] = count_reg[gi];
        end else begin : g_pad
            assign status[gi] = 1'b0;
        end
    end

endmodule
